// File: rtl/canny_mag_sequencer.sv
// canny_mag_sequencer: frame sequencer for the canny gradient-magnitude stage.
// Issues gradient reads, tracks the magnitude pipeline latency and writes back at matching addresses.
`default_nettype none

module canny_mag_sequencer #(
    parameter int STARTADDRESS = 770,
    parameter int ENDADDRESS   = 261758,
    parameter int ADDRWIDTH    = 18,
    parameter int MAGLATENCY   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 startEn,
    input  logic                 stall,
    input  logic                 abort,
    output logic                 magStartEn,
    output logic                 rdEn,
    output logic [ADDRWIDTH-1:0] rdAddr,
    output logic                 wrEn,
    output logic [ADDRWIDTH-1:0] wrAddr,
    output logic                 busy,
    output logic                 done
);

    localparam int CNTW = (MAGLATENCY > 1) ? $clog2(MAGLATENCY) : 1;
    localparam logic [ADDRWIDTH-1:0] START_A    = ADDRWIDTH'(STARTADDRESS);
    localparam logic [ADDRWIDTH-1:0] END_A      = ADDRWIDTH'(ENDADDRESS);
    localparam logic [CNTW-1:0]      DRAIN_LOAD = CNTW'(MAGLATENCY - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   magStart_q, magStart_d;
    logic                   rdEn_q, rdEn_d;
    logic [ADDRWIDTH-1:0]   rdAddr_q, rdAddr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic                   flush_d;
    logic [MAGLATENCY-1:0][ADDRWIDTH:0] pipe_q;

    // Registered outputs are computed one cycle ahead, so state_q is the state of the visible cycle.
    always_comb begin
        state_d    = state_q;
        magStart_d = 1'b0;
        rdEn_d     = 1'b0;
        rdAddr_d   = rdAddr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (startEn && !abort) begin
                    state_d    = PRIME;
                    magStart_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            PRIME: begin
                state_d  = RUN;
                rdEn_d   = 1'b1;
                rdAddr_d = START_A;
            end
            RUN: begin
                if (rdEn_q && (rdAddr_q == END_A)) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    rdEn_d = !stall;
                    if (rdEn_q) begin
                        rdAddr_d = rdAddr_q + ADDRWIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            magStart_d = 1'b0;
            rdEn_d     = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            flush_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            magStart_q <= 1'b0;
            rdEn_q     <= 1'b0;
            rdAddr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            magStart_q <= magStart_d;
            rdEn_q     <= rdEn_d;
            rdAddr_q   <= rdAddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    // Mirrors the enable-less magnitude datapath: shifts every cycle, stall gaps propagate as-is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_q <= '0;
        end else if (flush_d) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= {rdEn_q, rdAddr_q};
            for (int i = 1; i < MAGLATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign magStartEn = magStart_q;
    assign rdEn       = rdEn_q;
    assign rdAddr     = rdAddr_q;
    assign wrEn       = pipe_q[MAGLATENCY-1][ADDRWIDTH];
    assign wrAddr     = pipe_q[MAGLATENCY-1][ADDRWIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_canny_mag_sequencer.sv
// Directed bench for canny_mag_sequencer: nominal, stall, ignored start, abort, async reset, single-pixel frame.
`default_nettype none

module tb_canny_mag_sequencer;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, startEn, stall, abort, start2;
    logic          mag1, rd1, wr1, busy1, done1;
    logic [AW-1:0] rda1, wra1;
    logic          mag2, rd2, wr2, busy2, done2;
    logic [AW-1:0] rda2, wra2;
    logic [4:0]    st1, st2;

    assign st1 = {mag1, rd1, wr1, busy1, done1};
    assign st2 = {mag2, rd2, wr2, busy2, done2};

    int ncmp  = 0;
    int nfail = 0;

    canny_mag_sequencer #(
        .STARTADDRESS(4), .ENDADDRESS(9), .ADDRWIDTH(AW), .MAGLATENCY(3)
    ) dut (
        .clk(clk), .reset(reset), .startEn(startEn), .stall(stall), .abort(abort),
        .magStartEn(mag1), .rdEn(rd1), .rdAddr(rda1), .wrEn(wr1), .wrAddr(wra1),
        .busy(busy1), .done(done1)
    );

    canny_mag_sequencer #(
        .STARTADDRESS(4), .ENDADDRESS(4), .ADDRWIDTH(AW), .MAGLATENCY(3)
    ) dut_single (
        .clk(clk), .reset(reset), .startEn(start2), .stall(stall), .abort(abort),
        .magStartEn(mag2), .rdEn(rd2), .rdAddr(rda2), .wrEn(wr2), .wrAddr(wra2),
        .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe vector order: {magStartEn, rdEn, wrEn, busy, done}; address -1 means not checked.
    task automatic frame_chk(input string tag, input int k, input logic [4:0] obs_st,
                             input logic [AW-1:0] obs_rd, input logic [AW-1:0] obs_wr,
                             input logic [4:0] exp_st, input int exp_rd, input int exp_wr);
        chk($sformatf("%s c%0d strobes", tag, k), 32'(obs_st), 32'(exp_st));
        if (exp_rd >= 0) chk($sformatf("%s c%0d rdAddr", tag, k), 32'(obs_rd), exp_rd);
        if (exp_wr >= 0) chk($sformatf("%s c%0d wrAddr", tag, k), 32'(obs_wr), exp_wr);
    endtask

    function automatic logic [4:0] nom(input int k);
        return {k == 1, (k >= 2 && k <= 7), (k >= 5 && k <= 10), (k >= 1 && k <= 11), k == 11};
    endfunction

    task automatic nominal_frame(input string tag);
        logic [4:0] e;
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            e = nom(k);
            frame_chk(tag, k, st1, rda1, wra1, e, e[3] ? k + 2 : -1, e[2] ? k - 1 : -1);
            tick();
        end
    endtask

    initial begin
        logic [4:0] e;
        int nwr, ndone, nmag;
        reset = 1'b1; startEn = 1'b0; stall = 1'b0; abort = 1'b0; start2 = 1'b0;
        #2 reset = 1'b0;
        tick(); tick();
        frame_chk("reset", 0, st1, rda1, wra1, 5'b0, 0, 0);
        frame_chk("reset1", 0, st2, rda2, wra2, 5'b0, 0, 0);
        reset = 1'b1;
        tick();

        // 1: nominal frame
        nominal_frame("t1");

        // 2: stall sampled at the edges that produce cycles 4 and 5
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            e[4] = (k == 1);
            e[3] = (k == 2 || k == 3 || (k >= 6 && k <= 9));
            e[2] = (k == 5 || k == 6 || (k >= 9 && k <= 12));
            e[1] = (k <= 13);
            e[0] = (k == 13);
            frame_chk("t2", k, st1, rda1, wra1, e,
                      (k >= 2 && k <= 9) ? ((k <= 3) ? k + 2 : ((k <= 6) ? 6 : k)) : -1,
                      e[2] ? ((k <= 6) ? k - 1 : k - 3) : -1);
            stall = (k == 3 || k == 4);
            tick();
        end
        stall = 1'b0;

        // 3: extra start pulses while busy are ignored
        nwr = 0; ndone = 0; nmag = 0;
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            e = nom(k);
            frame_chk("t3", k, st1, rda1, wra1, e, e[3] ? k + 2 : -1, e[2] ? k - 1 : -1);
            nwr += int'(wr1); ndone += int'(done1); nmag += int'(mag1);
            startEn = (k == 3 || k == 11);
            tick();
        end
        startEn = 1'b0;
        chk("t3 wrEn count", nwr, 6);
        chk("t3 done count", ndone, 1);
        chk("t3 magStartEn count", nmag, 1);

        // 4: abort in cycle 6, then a full frame from a start in cycle 10
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            e = (k <= 6) ? nom(k) : 5'b0;
            frame_chk("t4", k, st1, rda1, wra1, e, e[3] ? k + 2 : -1, e[2] ? k - 1 : -1);
            abort = (k == 6);
            tick();
        end
        abort = 1'b0;
        nominal_frame("t4b");

        // 5: asynchronous reset in the middle of cycle 5
        startEn = 1'b1;
        tick();
        startEn = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            e = nom(k);
            frame_chk("t5", k, st1, rda1, wra1, e, e[3] ? k + 2 : -1, e[2] ? k - 1 : -1);
            if (k < 5) tick();
        end
        #2 reset = 1'b0;
        #1;
        frame_chk("t5 async", 5, st1, rda1, wra1, 5'b0, 0, 0);
        tick(); tick();
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("t5 idle c%0d", k), 32'(st1), 32'(5'b0));
        end

        // 6: single-pixel frame
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            e = {k == 1, k == 2, k == 5, k <= 6, k == 6};
            frame_chk("t6", k, st2, rda2, wra2, e, (k == 2) ? 4 : -1, (k == 5) ? 4 : -1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
